rx_buffer_reader: RTL and testbench

Downstream consumer of the rx packet ring buffer. It reads committed frames (2-word header plus payload) from the internal dual-port memory's read port. Each frame is re-emitted as a 64-bit AXI4-Stream toward the host DMA engine, with frame metadata on tuser. After the last beat is accepted, it frees the frame's buffer space by advancing commited_rd_address.

---
 rtl/rx_buffer_reader_pkg.sv | 35 +++
 rtl/rx_reader_skid.sv | 46 ++++
 rtl/rx_buffer_reader.sv | 162 ++++++++++++++++
 tb/tb_rx_buffer_reader.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_buffer_reader_pkg.sv
// Shared definitions for the rx ring-buffer reader: address width, length limit,
// header/tuser field positions and reader FSM states.
package rx_buffer_reader_pkg;

  localparam int RB_ADDR_W  = 15;
  localparam int RB_MAX_LEN = 9216;

  localparam int HDR_SRC_LSB = 0;
  localparam int HDR_DST_LSB = 16;
  localparam int HDR_LEN_LSB = 32;

  localparam int TU_LEN_LSB = 0;
  localparam int TU_SRC_LSB = 16;
  localparam int TU_DST_LSB = 24;
  localparam int TU_TS_LSB  = 32;

  // Output beat carried through the skid buffer: {tdata, tkeep, tlast}
  localparam int BEAT_W = 64 + 8 + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_A,
    ST_HDR_B,
    ST_HDR_C,
    ST_DATA,
    ST_COMMIT,
    ST_SKIP
  } rd_state_t;

  function automatic logic [7:0] last_keep(input logic [15:0] len);
    if (len[2:0] == 3'd0) return 8'hFF;
    return (8'h01 << len[2:0]) - 8'h01;
  endfunction

endpackage

// File: rtl/rx_reader_skid.sv
// Two-entry valid/ready skid buffer; the head entry drives the output directly.
module rx_reader_skid #(
  parameter int DATA_W = 73
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic [1:0]        level
);

  logic [DATA_W-1:0] head_q;
  logic [DATA_W-1:0] tail_q;
  logic [1:0]        cnt_q;
  logic              pop;
  logic              push;

  assign m_valid = (cnt_q != 2'd0);
  assign m_data  = head_q;
  assign level   = cnt_q;
  assign pop     = m_valid && m_ready;
  assign push    = s_valid && ((cnt_q != 2'd2) || pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
    end else begin
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
      if (pop && (cnt_q == 2'd2))
        head_q <= tail_q;
      else if (push && ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop)))
        head_q <= s_data;
    end
  end

  // Tail is never observable until promoted, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push && (((cnt_q == 2'd1) && !pop) || ((cnt_q == 2'd2) && pop)))
      tail_q <= s_data;
  end

endmodule

// File: rtl/rx_buffer_reader.sv
// Reads committed frames from the rx ring buffer and streams them out on AXI4-Stream.
// Optional frame statistics counters are built when RX_BUFFER_READER_STATS_EN is defined.
module rx_buffer_reader
  import rx_buffer_reader_pkg::*;
#(
  parameter int ADDR_W  = RB_ADDR_W,
  parameter int MAX_LEN = RB_MAX_LEN
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] commited_wr_address,
  output logic [ADDR_W-1:0] commited_rd_address,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [63:0]       rd_data,
  output logic [63:0]       m_axis_tdata,
  output logic [7:0]        m_axis_tkeep,
  output logic [127:0]      m_axis_tuser,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic [31:0]       frames_out,
  output logic [31:0]       frames_err
);

  rd_state_t         state_q, state_d;
  logic [7:0]        src_q, dst_q;
  logic [15:0]       len_q;
  logic [63:0]       ts_q;
  logic [ADDR_W-1:0] rd_idx_q;
  logic [ADDR_W-1:0] wlen;
  logic [ADDR_W-1:0] next_hdr;
  logic [16:0]       len_rnd;
  logic              len_ok, more, room, issue, beat_pop;
  logic [1:0]        level;
  logic [2:0]        occ;
  logic              vld_p1, last_p1;
  logic [7:0]        keep_p1;
  logic [BEAT_W-1:0] beat_out;

  assign len_rnd  = {1'b0, len_q} + 17'd7;
  assign wlen     = ADDR_W'(len_rnd >> 3);
  assign next_hdr = commited_rd_address + ADDR_W'(2) + wlen;
  assign len_ok   = (len_q != 16'd0) && (int'(len_q) <= MAX_LEN);
  assign beat_pop = m_axis_tvalid && m_axis_tready;

  // Reserve a skid slot for every read in flight; a beat leaving this cycle frees one.
  assign occ   = {1'b0, level} + {2'b00, vld_p1};
  assign room  = (occ <= ({2'b00, beat_pop} + 3'd1));
  assign more  = (rd_idx_q < wlen);
  assign issue = more && room &&
                 (((state_q == ST_HDR_C) && len_ok) || (state_q == ST_DATA));

  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    rd_addr = '0;
    case (state_q)
      ST_IDLE:   if (commited_wr_address != commited_rd_address) state_d = ST_HDR_A;
      ST_HDR_A: begin
        rd_en   = 1'b1;
        rd_addr = commited_rd_address;
        state_d = ST_HDR_B;
      end
      ST_HDR_B: begin
        rd_en   = 1'b1;
        rd_addr = commited_rd_address + ADDR_W'(1);
        state_d = ST_HDR_C;
      end
      ST_HDR_C:  state_d = len_ok ? ST_DATA : ST_SKIP;
      ST_DATA:   if (beat_pop && m_axis_tlast) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      ST_SKIP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (issue) begin
      rd_en   = 1'b1;
      rd_addr = commited_rd_address + ADDR_W'(2) + rd_idx_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q             <= ST_IDLE;
      commited_rd_address <= '0;
      rd_idx_q            <= '0;
      vld_p1              <= 1'b0;
      src_q               <= '0;
      dst_q               <= '0;
      len_q               <= '0;
      ts_q                <= '0;
    end else begin
      state_q <= state_d;
      vld_p1  <= issue;
      if (state_q == ST_HDR_A)
        rd_idx_q <= '0;
      else if (issue)
        rd_idx_q <= rd_idx_q + ADDR_W'(1);
      if (state_q == ST_HDR_B) begin
        src_q <= rd_data[HDR_SRC_LSB +: 8];
        dst_q <= rd_data[HDR_DST_LSB +: 8];
        len_q <= rd_data[HDR_LEN_LSB +: 16];
      end
      if (state_q == ST_HDR_C) ts_q <= rd_data;
      if (state_q == ST_COMMIT)
        commited_rd_address <= next_hdr;
      else if (state_q == ST_SKIP)
        commited_rd_address <= commited_wr_address;
    end
  end

  // p1: beat attributes travel with the read until rd_data returns
  always_ff @(posedge clk) begin
    last_p1 <= (rd_idx_q == (wlen - ADDR_W'(1)));
    keep_p1 <= (rd_idx_q == (wlen - ADDR_W'(1))) ? last_keep(len_q) : 8'hFF;
  end

  rx_reader_skid #(
    .DATA_W (BEAT_W)
  ) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .s_valid (vld_p1),
    .s_data  ({rd_data, keep_p1, last_p1}),
    .m_valid (m_axis_tvalid),
    .m_data  (beat_out),
    .m_ready (m_axis_tready),
    .level   (level)
  );

  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast} = beat_out;

  always_comb begin
    m_axis_tuser                    = '0;
    m_axis_tuser[TU_LEN_LSB +: 16]  = len_q;
    m_axis_tuser[TU_SRC_LSB +: 8]   = src_q;
    m_axis_tuser[TU_DST_LSB +: 8]   = dst_q;
    m_axis_tuser[TU_TS_LSB +: 64]   = ts_q;
  end

`ifdef RX_BUFFER_READER_STATS_EN
  logic [31:0] frames_out_q;
  logic [31:0] frames_err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frames_out_q <= '0;
      frames_err_q <= '0;
    end else begin
      if (beat_pop && m_axis_tlast) frames_out_q <= frames_out_q + 32'd1;
      if (state_q == ST_SKIP)       frames_err_q <= frames_err_q + 32'd1;
    end
  end

  assign frames_out = frames_out_q;
  assign frames_err = frames_err_q;
`else
  assign frames_out = '0;
  assign frames_err = '0;
`endif

endmodule

// File: tb/tb_rx_buffer_reader.sv
// Randomized bench for rx_buffer_reader: a memory model holds frames, a queue of expected beats
// derived from frame length/header is compared against every output handshake.
module tb_rx_buffer_reader;

  localparam int AW = 15;
`ifdef RX_BUFFER_READER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] commited_wr_address;
  logic [AW-1:0] commited_rd_address;
  logic [AW-1:0] rd_addr;
  logic          rd_en;
  logic [63:0]   rd_data = '0;
  logic [63:0]   m_axis_tdata;
  logic [7:0]    m_axis_tkeep;
  logic [127:0]  m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready;
  logic [31:0]   frames_out;
  logic [31:0]   frames_err;

  always #5 clk = ~clk;

  rx_buffer_reader dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .commited_wr_address (commited_wr_address),
    .commited_rd_address (commited_rd_address),
    .rd_addr             (rd_addr),
    .rd_en               (rd_en),
    .rd_data             (rd_data),
    .m_axis_tdata        (m_axis_tdata),
    .m_axis_tkeep        (m_axis_tkeep),
    .m_axis_tuser        (m_axis_tuser),
    .m_axis_tvalid       (m_axis_tvalid),
    .m_axis_tlast        (m_axis_tlast),
    .m_axis_tready       (m_axis_tready),
    .frames_out          (frames_out),
    .frames_err          (frames_err)
  );

  logic [63:0] mem [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  typedef struct {
    logic [63:0]  d;
    logic [7:0]   k;
    logic         l;
    logic [127:0] u;
  } beat_t;

  beat_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    tr_mode = 0;
  int    frames_exp = 0;
  int    errs_exp = 0;
  logic  prev_stall = 1'b0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] stat_exp(input int n);
    return STATS ? 32'(n) : 32'd0;
  endfunction

  // Sink readiness: 0 = always ready, 1 = random, 2 = held off
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (tr_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = 1'($urandom_range(0, 1));
        default: m_axis_tready = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) chk("tvalid_hold", 128'(m_axis_tvalid), 128'd1);
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 128'd1, 128'd0);
        end else begin
          chk("tdata", 128'(m_axis_tdata), 128'(exp_q[0].d));
          chk("tkeep", 128'(m_axis_tkeep), 128'(exp_q[0].k));
          chk("tlast", 128'(m_axis_tlast), 128'(exp_q[0].l));
          chk("tuser", m_axis_tuser, exp_q[0].u);
          exp_q.delete(0);
        end
      end
      prev_stall <= m_axis_tvalid && !m_axis_tready;
    end
  end

  // Places a frame at h and queues its expected beats when the length is legal.
  task automatic write_frame(input logic [AW-1:0] h, input int len, output logic [AW-1:0] nh);
    int            w;
    logic [7:0]    src, dst;
    logic [63:0]   ts, word;
    logic [AW-1:0] a;
    beat_t         b;
    w   = (len + 7) / 8;
    src = 8'($urandom);
    dst = 8'($urandom);
    ts  = {$urandom, $urandom};
    mem[h]            = {16'd0, 16'(len), 8'd0, dst, 8'd0, src};
    mem[h + AW'(1)]   = ts;
    if (len > 0 && len <= 9216) begin
      for (int i = 0; i < w; i++) begin
        a      = h + AW'(2 + i);
        word   = {$urandom, $urandom};
        mem[a] = word;
        b.d = word;
        b.l = (i == w - 1);
        b.k = (b.l && (len % 8) != 0) ? 8'((1 << (len % 8)) - 1) : 8'hFF;
        b.u = {32'd0, ts, dst, src, 16'(len)};
        exp_q.push_back(b);
      end
    end
    nh = h + AW'(2 + w);
  endtask

  task automatic set_wr(input logic [AW-1:0] v);
    @(posedge clk);
    #1;
    commited_wr_address = v;
  endtask

  task automatic wait_last(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) seen = 1'b1;
    end
    if (!seen) chk("tlast_timeout", 128'd0, 128'd1);
  endtask

  task automatic wait_rd(input logic [AW-1:0] v, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (commited_rd_address == v) break;
    end
    chk("rd_ptr", 128'(commited_rd_address), 128'(v));
  endtask

  task automatic run_frame(input logic [AW-1:0] h, input int len, input int mode);
    logic [AW-1:0] nh;
    write_frame(h, len, nh);
    tr_mode = mode;
    set_wr(nh);
    wait_last(400);
    wait_rd(nh, 20);
    tr_mode = 0;
    frames_exp++;
    chk("frames_out", 128'(frames_out), 128'(stat_exp(frames_exp)));
    chk("drain", 128'(exp_q.size()), 128'd0);
  endtask

  task automatic run_skip(input logic [AW-1:0] h, input int len, input logic [AW-1:0] wr);
    logic [AW-1:0] nh;
    write_frame(h, len, nh);
    set_wr(wr);
    wait_rd(wr, 50);
    errs_exp++;
    repeat (3) @(posedge clk);
    #1;
    chk("frames_err", 128'(frames_err), 128'(stat_exp(errs_exp)));
    chk("skip_no_beats", 128'(exp_q.size()), 128'd0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_tvalid", 128'(m_axis_tvalid), 128'd0);
    chk("rst_tlast", 128'(m_axis_tlast), 128'd0);
    chk("rst_tkeep", 128'(m_axis_tkeep), 128'd0);
    chk("rst_tdata", 128'(m_axis_tdata), 128'd0);
    chk("rst_tuser", m_axis_tuser, 128'd0);
    chk("rst_rd_en", 128'(rd_en), 128'd0);
    chk("rst_rd_addr", 128'(rd_addr), 128'd0);
    chk("rst_rd_ptr", 128'(commited_rd_address), 128'd0);
    chk("rst_frames_out", 128'(frames_out), 128'd0);
    chk("rst_frames_err", 128'(frames_err), 128'd0);
  endtask

  initial begin
    int            n;
    logic [AW-1:0] nh;
    reset_n             = 1'b0;
    commited_wr_address = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs();
    @(negedge clk);
    reset_n = 1'b1;

    // Empty header at 0 moves the read pointer to 2
    run_skip(AW'(0), 0, AW'(2));

    // L=64 at H=2: latency, full-rate beats, commit one cycle after the last handshake
    write_frame(AW'(2), 64, nh);
    set_wr(nh);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (m_axis_tvalid) begin
        n = i;
        break;
      end
    end
    chk("latency", 128'(n), 128'd5);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("tput_hs", 128'(m_axis_tvalid && m_axis_tready), 128'd1);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("commit_ptr", 128'(commited_rd_address), 128'd12);
    frames_exp++;
    chk("frames_out", 128'(frames_out), 128'(stat_exp(frames_exp)));
    chk("drain", 128'(exp_q.size()), 128'd0);

    run_frame(AW'(12), 61, 0);
    run_frame(AW'(22), 64, 1);
    run_frame(AW'(32), 37, 1);

    // Oversize length flushes the ring to the write pointer
    run_skip(AW'(39), 9217, AW'(100));
    run_skip(AW'(100), 0, AW'((1 << AW) - 3));

    // Payload wraps through address 0
    run_frame(AW'((1 << AW) - 3), 40, 0);
    chk("wrap_ptr", 128'(commited_rd_address), 128'd4);

    // Fresh start, back-to-back frames, reset pulsed while frame 2 is stalled
    reset_n = 1'b0;
    commited_wr_address = '0;
    exp_q.delete();
    frames_exp = 0;
    errs_exp   = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    write_frame(AW'(0), 16, nh);
    write_frame(nh, 8, nh);
    set_wr(nh);
    wait_last(100);
    tr_mode = 2;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (m_axis_tvalid) begin
        n = 1;
        break;
      end
    end
    chk("frame2_valid", 128'(n), 128'd1);
    chk("frames_out_pre_rst", 128'(frames_out), 128'(stat_exp(1)));
    chk("rd_ptr_pre_rst", 128'(commited_rd_address), 128'd4);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs();
    exp_q.delete();
    commited_wr_address = '0;
    tr_mode = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_ptr", 128'(commited_rd_address), 128'd0);
    chk("post_rst_tvalid", 128'(m_axis_tvalid), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
